// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types, frame and scan-code constants
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] ENTER = 8'h5A;
  localparam logic [7:0] ESC   = 8'h76;
  localparam logic [7:0] SPACE = 8'h29;

  // Odd parity holds when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - PS/2 pin synchronizers, clock deglitch filter and falling-edge strobe
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_fall,
  output logic o_dat_sync
);

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_dat_sync;
  logic [FILTER_LEN-1:0] r_filter;
  logic                  r_filt_clk;
  logic                  r_clk_fall;
  logic                  w_all_low;
  logic                  w_all_high;

  assign w_all_low  = (r_filter == '0);
  assign w_all_high = &r_filter;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
    end
  end

  // Level only changes after FILTER_LEN agreeing samples; strobe fires on the 1->0 change
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filter   <= '1;
      r_filt_clk <= 1'b1;
      r_clk_fall <= 1'b0;
    end else begin
      r_filter   <= {r_filter[FILTER_LEN-2:0], r_clk_sync[1]};
      r_clk_fall <= r_filt_clk & w_all_low;
      if (w_all_low)
        r_filt_clk <= 1'b0;
      else if (w_all_high)
        r_filt_clk <= 1'b1;
    end
  end

  assign o_clk_fall = r_clk_fall;
  assign o_dat_sync = r_dat_sync[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame receiver producing validated scan-code strobes
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error,
  output logic       busy
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       r_state;
  ps2_state_t       w_state_nxt;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_parity;
  logic             w_parity_nxt;
  logic [7:0]       r_rx_data;
  logic [7:0]       w_rx_data_nxt;
  logic             r_rx_en;
  logic             w_rx_en_nxt;
  logic             r_frame_err;
  logic             w_frame_err_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_clk_fall;
  logic             w_dat;
  logic             w_timeout;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .i_clk      (CLOCK_50),
    .i_rst      (reset),
    .i_ps2_clk  (PS2_CLK),
    .i_ps2_dat  (PS2_DAT),
    .o_clk_fall (w_clk_fall),
    .o_dat_sync (w_dat)
  );

  // A strobe in the timeout cycle wins, so the timeout is gated by the absence of a strobe
  assign w_timeout = (r_state != IDLE) && !w_clk_fall && (r_tmo_cnt == TMO_LAST);

  // Frame state register, datapath registers and saturating inter-edge timeout counter
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_data      <= '0;
      r_parity    <= 1'b0;
      r_rx_data   <= '0;
      r_rx_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_data      <= w_data_nxt;
      r_parity    <= w_parity_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_en     <= w_rx_en_nxt;
      r_frame_err <= w_frame_err_nxt;
      if (w_clk_fall || r_state == IDLE)
        r_tmo_cnt <= '0;
      else if (r_tmo_cnt != '1)
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Next-state and datapath decisions, taken only on sample strobes or timeout
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_data_nxt      = r_data;
    w_parity_nxt    = r_parity;
    w_rx_data_nxt   = r_rx_data;
    w_rx_en_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;
    if (w_clk_fall) begin
      case (r_state)
        IDLE: begin
          if (w_dat == START_BIT) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
            w_data_nxt    = '0;
          end
        end
        DATA: begin
          w_data_nxt[r_bit_cnt] = w_dat;
          if (r_bit_cnt == 3'(DATA_BITS - 1))
            w_state_nxt = PARITY;
          else
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        end
        PARITY: begin
          w_parity_nxt = w_dat;
          w_state_nxt  = STOP;
        end
        STOP: begin
          if (w_dat == STOP_BIT && odd_parity_ok(r_data, r_parity)) begin
            w_rx_data_nxt = r_data;
            w_rx_en_nxt   = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt     = IDLE;
      w_data_nxt      = '0;
      w_frame_err_nxt = 1'b1;
    end
  end

  assign received_data    = r_rx_data;
  assign received_data_en = r_rx_en;
  assign frame_error      = r_frame_err;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - randomized self-checking bench for ps2_frame_rx against a frame-level model
module tb_ps2_frame_rx;

  localparam int FL  = 8;
  localparam int TMO = 400;
  localparam int H   = 25;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_error;
  logic       busy;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  exp_t exp_q[$];
  logic [7:0] last_good;
  logic       prev_strb;

  ps2_frame_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .PS2_CLK          (ps2_clk),
    .PS2_DAT          (ps2_dat),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .frame_error      (frame_error),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every output strobe is matched in order against the frame-level expectation queue
  always @(negedge clk) begin
    if (reset) begin
      last_good = 8'h00;
      prev_strb = 1'b0;
    end else begin
      if (received_data_en || frame_error) begin
        chk("strobe_exclusive", {31'd0, received_data_en & frame_error}, 0);
        chk("strobe_single_cycle", {31'd0, prev_strb}, 0);
        chk("busy_at_strobe", {31'd0, busy}, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind_err", {31'd0, frame_error}, {31'd0, e.err});
          if (e.err) begin
            chk("data_held_on_error", {24'd0, received_data}, {24'd0, last_good});
          end else begin
            chk("rx_data", {24'd0, received_data}, {24'd0, e.data});
            last_good = e.data;
          end
        end
      end
      prev_strb = received_data_en | frame_error;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(H - 11);
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic par;
    par = ~(^b) ^ bad_par;
    if (bad_par || bad_stop) exp_q.push_back({1'b1, 8'h00});
    else                     exp_q.push_back({1'b0, b});
    send_bit(1'b0, 1'b0);
    chk("busy_in_frame", {31'd0, busy}, 1);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 4));
    send_bit(par, 1'b0);
    send_bit(~bad_stop, 1'b0);
    ps2_dat = 1'b1;
    chk("busy_after_frame", {31'd0, busy}, 0);
  endtask

  initial begin
    logic [7:0] d;
    int         t0;
    int         t_err;
    bit         seen;
    int         lat;
    int         kind;

    n_cmp   = 0;
    n_bad   = 0;
    cyc     = 0;
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    last_good = 8'h00;
    prev_strb = 1'b0;
    wait_cyc(4);
    chk("reset_data", {24'd0, received_data}, 0);
    chk("reset_en", {31'd0, received_data_en}, 0);
    chk("reset_err", {31'd0, frame_error}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    wait_cyc(FL + 4);

    send_frame(8'h1C, 0, 0, 0);
    wait_cyc(2 * H);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    wait_cyc(H);
    send_frame(8'h23, 1, 0, 0);
    send_frame(8'h5A, 0, 0, 0);
    send_frame(8'h76, 0, 1, 0);
    wait_cyc(H);
    send_frame(8'h1C, 0, 0, 1);
    wait_cyc(H);

    // Clock stops after five data bits: timeout must abort the frame
    d = 8'($urandom);
    exp_q.push_back({1'b1, 8'h00});
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    ps2_dat = d[4];
    wait_cyc(H);
    ps2_clk = 1'b0;
    t0 = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
    seen  = 0;
    t_err = 0;
    while (!seen && (cyc < t0 + TMO + FL + 40)) begin
      @(negedge clk);
      if (frame_error) begin
        seen  = 1;
        t_err = cyc;
      end
    end
    chk("timeout_seen", {31'd0, seen}, 1);
    lat = t_err - t0;
    if (seen) chk("timeout_latency_window", {31'd0, (lat >= TMO + FL + 3) && (lat <= TMO + FL + 5)}, 1);
    wait_cyc(2);
    chk("busy_after_timeout", {31'd0, busy}, 0);
    ps2_dat = 1'b1;
    wait_cyc(H);
    send_frame(8'h29, 0, 0, 0);

    // Randomized frames with random faults and random inter-frame gaps
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 4);
      send_frame(d, kind == 3, kind == 4, kind == 2);
      wait_cyc($urandom_range(0, 2) * H);
    end

    // Reset in the middle of a frame aborts it silently
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(KEY_A_BIT(i), 1'b0);
    reset = 1'b1;
    #1;
    chk("midreset_data", {24'd0, received_data}, 0);
    chk("midreset_en", {31'd0, received_data_en}, 0);
    chk("midreset_err", {31'd0, frame_error}, 0);
    chk("midreset_busy", {31'd0, busy}, 0);
    wait_cyc(5);
    reset = 1'b0;
    ps2_dat = 1'b1;
    wait_cyc(FL + 6);
    send_frame(8'h1C, 0, 0, 0);

    wait_cyc(3 * H);
    chk("expect_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic KEY_A_BIT(input int i);
    logic [7:0] v;
    v = 8'h1C;
    return v[i];
  endfunction

endmodule
